// File: rtl/wb_arbiter2.sv
// wb_arbiter2: round-robin two-master Wishbone classic arbiter with a per-cycle bus watchdog.
module wb_arbiter2 #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] iwbs_addr_i,
  input  logic        iwbs_cyc_i,
  input  logic        iwbs_stb_i,
  output logic [31:0] iwbs_dat_o,
  output logic        iwbs_ack_o,
  output logic        iwbs_err_o,
  input  logic [31:0] dwbs_addr_i,
  input  logic [31:0] dwbs_dat_i,
  input  logic [3:0]  dwbs_sel_i,
  input  logic        dwbs_cyc_i,
  input  logic        dwbs_stb_i,
  input  logic        dwbs_we_i,
  output logic [31:0] dwbs_dat_o,
  output logic        dwbs_ack_o,
  output logic        dwbs_err_o,
  output logic [31:0] wbm_addr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i
);
  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] WD_LAST = W'(TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;
  state_t state_q, state_d;
  logic last_d_q, last_d_d;
  logic [W-1:0] wdog_q, wdog_d;
  logic req_i, req_d, gi, gd, cyc_x, stb_x, hit;
  assign req_i = iwbs_cyc_i & iwbs_stb_i;
  assign req_d = dwbs_cyc_i & dwbs_stb_i;
  assign gi = state_q == GNT_I;
  assign gd = state_q == GNT_D;
  assign cyc_x = gi ? iwbs_cyc_i : gd & dwbs_cyc_i;
  assign stb_x = gi ? iwbs_stb_i : gd & dwbs_stb_i;
  // A slave ack or err in the final watchdog cycle pre-empts the timeout.
  assign hit = cyc_x & stb_x & ~wbm_ack_i & ~wbm_err_i & (wdog_q == WD_LAST);
  always_comb begin
    state_d = state_q;
    wdog_d = '0;
    if (state_q == IDLE) begin
      if (req_i & (~req_d | last_d_q)) state_d = GNT_I;
      else if (req_d) state_d = GNT_D;
    end else if (~cyc_x) begin
      state_d = gi ? (req_d ? GNT_D : IDLE) : (req_i ? GNT_I : IDLE);
    end else if (stb_x & ~wbm_ack_i & ~wbm_err_i & ~hit) begin
      wdog_d = wdog_q + 1'b1;
    end
    last_d_d = (state_d == IDLE) ? last_d_q : (state_d == GNT_D);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      last_d_q <= 1'b1;
      wdog_q <= '0;
    end else begin
      state_q <= state_d;
      last_d_q <= last_d_d;
      wdog_q <= wdog_d;
    end
  end
  assign wbm_cyc_o = cyc_x;
  assign wbm_stb_o = stb_x & ~hit;
  assign wbm_we_o = gd & dwbs_we_i;
  assign wbm_sel_o = gi ? 4'hF : gd ? dwbs_sel_i : 4'h0;
  assign wbm_addr_o = gi ? iwbs_addr_i : gd ? dwbs_addr_i : 32'h0;
  assign wbm_dat_o = gd ? dwbs_dat_i : 32'h0;
  assign iwbs_dat_o = gi ? wbm_dat_i : 32'h0;
  assign iwbs_ack_o = gi & wbm_ack_i;
  assign iwbs_err_o = gi & (wbm_err_i | hit);
  assign dwbs_dat_o = gd ? wbm_dat_i : 32'h0;
  assign dwbs_ack_o = gd & wbm_ack_i;
  assign dwbs_err_o = gd & (wbm_err_i | hit);
endmodule

// File: tb/tb_wb_arbiter2.sv
// tb_wb_arbiter2: cycle-by-cycle vector table through a scoreboard queue, plus randomized data writes.
module tb_wb_arbiter2;
  typedef struct packed {
    logic rst, ic, is, dc, ds, we, ack, err;
    logic [1:0] g;
    logic stb, ia, ie, da, de;
  } vec_t;
  logic clk = 1'b0;
  logic rst, icyc, istb, dcyc, dstb, dwe, wack, werr;
  logic [31:0] ia_r = 32'h1000_0040, da_r = 32'h0000_0100, dd_r = 32'hDEAD_BEEF, sd_r = 32'hCAFE_F00D;
  logic [3:0] ds_r = 4'b0011;
  logic [31:0] iwbs_dat_o, dwbs_dat_o, wbm_addr_o, wbm_dat_o;
  logic [3:0] wbm_sel_o;
  logic iwbs_ack_o, iwbs_err_o, dwbs_ack_o, dwbs_err_o, wbm_cyc_o, wbm_stb_o, wbm_we_o;
  vec_t tbl[$];
  logic [138:0] exp_q[$];
  int nvec = 0, nmis = 0;
  always #5 clk = ~clk;
  wb_arbiter2 #(.TIMEOUT(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .iwbs_addr_i(ia_r), .iwbs_cyc_i(icyc), .iwbs_stb_i(istb),
    .iwbs_dat_o(iwbs_dat_o), .iwbs_ack_o(iwbs_ack_o), .iwbs_err_o(iwbs_err_o),
    .dwbs_addr_i(da_r), .dwbs_dat_i(dd_r), .dwbs_sel_i(ds_r),
    .dwbs_cyc_i(dcyc), .dwbs_stb_i(dstb), .dwbs_we_i(dwe),
    .dwbs_dat_o(dwbs_dat_o), .dwbs_ack_o(dwbs_ack_o), .dwbs_err_o(dwbs_err_o),
    .wbm_addr_o(wbm_addr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_dat_i(sd_r), .wbm_ack_i(wack), .wbm_err_i(werr)
  );
  function automatic logic [138:0] actual();
    return {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_addr_o, wbm_dat_o,
            iwbs_dat_o, iwbs_ack_o, iwbs_err_o, dwbs_dat_o, dwbs_ack_o, dwbs_err_o};
  endfunction
  // Expected bus view: g selects which master the slave port mirrors (0 none, 1 I, 2 D).
  function automatic logic [138:0] model(vec_t v);
    if (v.g == 2'd1)
      return {v.ic, v.stb, 1'b0, 4'hF, ia_r, 32'h0, sd_r, v.ia, v.ie, 32'h0, 1'b0, 1'b0};
    if (v.g == 2'd2)
      return {v.dc, v.stb, v.we, ds_r, da_r, dd_r, 32'h0, 1'b0, 1'b0, sd_r, v.da, v.de};
    return '0;
  endfunction
  task automatic add(input int n, input bit r, ic, is, dc, ds, we, ack, err,
                     input bit [1:0] g, input bit stb, ia, ie, da, de);
    repeat (n) tbl.push_back('{r, ic, is, dc, ds, we, ack, err, g, stb, ia, ie, da, de});
  endtask
  task automatic chk(input string name, input logic [138:0] act, input logic [138:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask
  initial begin
    add(1, 1, 1,1,1,1,0, 0,0, 0,0, 0,0,0,0);
    add(1, 0, 1,1,1,1,0, 0,0, 0,0, 0,0,0,0);
    add(1, 0, 1,1,1,1,0, 0,0, 1,1, 0,0,0,0);
    add(1, 0, 1,1,1,1,0, 1,0, 1,1, 1,0,0,0);
    add(1, 0, 0,0,1,1,0, 0,0, 1,0, 0,0,0,0);
    add(1, 0, 0,0,1,1,1, 0,0, 2,1, 0,0,0,0);
    add(1, 0, 0,0,1,1,1, 1,0, 2,1, 0,0,1,0);
    add(1, 0, 0,0,0,0,1, 0,0, 2,0, 0,0,0,0);
    add(1, 0, 0,0,0,0,0, 0,0, 0,0, 0,0,0,0);
    add(1, 0, 1,1,1,1,0, 0,0, 0,0, 0,0,0,0);
    add(1, 0, 1,1,1,1,0, 1,0, 1,1, 1,0,0,0);
    add(1, 0, 0,0,1,1,0, 0,0, 1,0, 0,0,0,0);
    add(1, 0, 1,1,1,1,0, 1,0, 2,1, 0,0,1,0);
    add(1, 0, 1,1,0,0,0, 0,0, 2,0, 0,0,0,0);
    add(1, 0, 1,1,1,1,0, 1,0, 1,1, 1,0,0,0);
    add(1, 0, 0,0,1,1,0, 0,0, 1,0, 0,0,0,0);
    for (int b = 0; b < 3; b++) begin
      add(1, 0, 1,1,1,1,0, 1,0, 2,1, 0,0,1,0);
      if (b < 2) add(1, 0, 1,1,1,0,0, 0,0, 2,0, 0,0,0,0);
    end
    add(1, 0, 1,1,0,0,0, 0,0, 2,0, 0,0,0,0);
    add(7, 0, 1,1,0,0,0, 0,0, 1,1, 0,0,0,0);
    add(1, 0, 1,1,0,0,0, 0,0, 1,0, 0,1,0,0);
    add(7, 0, 1,1,0,0,0, 0,0, 1,1, 0,0,0,0);
    add(1, 0, 1,1,0,0,0, 1,0, 1,1, 1,0,0,0);
    add(1, 0, 1,1,0,0,0, 0,1, 1,1, 0,1,0,0);
    add(1, 0, 0,0,1,1,1, 0,0, 1,0, 0,0,0,0);
    add(1, 0, 0,0,1,1,1, 0,0, 2,1, 0,0,0,0);
    add(1, 1, 0,0,1,1,1, 0,0, 2,1, 0,0,0,0);
    add(1, 0, 0,0,1,1,1, 1,0, 0,0, 0,0,0,0);
    add(7, 0, 0,0,1,1,1, 0,0, 2,1, 0,0,0,0);
    add(1, 0, 0,0,1,1,1, 0,0, 2,0, 0,0,0,1);
    add(1, 0, 0,0,0,0,1, 0,0, 2,0, 0,0,0,0);
    add(1, 0, 0,0,0,0,0, 0,0, 0,0, 0,0,0,0);
    {rst, icyc, istb, dcyc, dstb, dwe, wack, werr} = 8'b1111_1000;
    @(posedge clk); #1;
    for (int i = 0; i < tbl.size(); i++) begin
      {rst, icyc, istb, dcyc, dstb, dwe, wack, werr} =
        {tbl[i].rst, tbl[i].ic, tbl[i].is, tbl[i].dc, tbl[i].ds, tbl[i].we, tbl[i].ack, tbl[i].err};
      exp_q.push_back(model(tbl[i]));
      @(negedge clk);
      chk($sformatf("vec%0d", i), actual(), exp_q.pop_front());
      @(posedge clk); #1;
    end
    for (int k = 0; k < 3; k++) begin
      da_r = $urandom;
      dd_r = $urandom;
      ds_r = 4'($urandom_range(1, 15));
      {icyc, istb, dcyc, dstb, dwe, wack, werr} = 7'b0011100;
      exp_q.push_back({3'b111, ds_r, da_r, dd_r, 32'h0, 2'b00, sd_r, 2'b00});
      for (int t = 0; t < 4; t++) begin
        @(negedge clk);
        if (wbm_cyc_o) break;
      end
      chk($sformatf("rand_req%0d", k), actual(), exp_q.pop_front());
      @(posedge clk); #1;
      wack = 1'b1;
      exp_q.push_back({3'b111, ds_r, da_r, dd_r, 32'h0, 2'b00, sd_r, 2'b10});
      @(negedge clk);
      chk($sformatf("rand_ack%0d", k), actual(), exp_q.pop_front());
      @(posedge clk); #1;
      {dcyc, dstb, wack} = 3'b000;
      @(posedge clk); #1;
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
